// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - hazard/flow-control unit: stall and flush strobes, stage valids, perf counters
//
// Ports:
//   clock_i, reset_i            clock and synchronous active-high reset
//   if_stall_i, mem_stall_i     instruction / data cache not ready
//   ex_busy_i                   multi-cycle ALU op in progress
//   ex_branch_taken_i           EX resolved a taken branch/jump
//   id_rs1_i, id_rs2_i          decode source registers
//   id_uses_rs1_i/_rs2_i        decode instruction reads rs1 / rs2
//   ex_rd_i, ex_mem_read_i      execute destination and load flag
//   stall_o[k]                  register feeding stage k holds
//   flush_o[k]                  register of stage k loads a bubble
//   stage_valid_o[k]            stage k holds a real instruction (bit 0 always 1)
//   retired_count_o             instructions leaving WB (saturating)
//   stall_cycles_o              cycles with any stall (saturating)
//   flush_count_o               accepted branch redirects (saturating)
module pipeline_control #(
    parameter int NUM_STAGES     = 5,
    parameter int EX_STAGE       = 2,
    parameter int MEM_STAGE      = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      if_stall_i,
    input  logic                      mem_stall_i,
    input  logic                      ex_busy_i,
    input  logic                      ex_branch_taken_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_mem_read_i,
    output logic [NUM_STAGES-1:0]     stall_o,
    output logic [NUM_STAGES-1:0]     flush_o,
    output logic [NUM_STAGES-1:0]     stage_valid_o,
    output logic [COUNTER_WIDTH-1:0]  retired_count_o,
    output logic [COUNTER_WIDTH-1:0]  stall_cycles_o,
    output logic [COUNTER_WIDTH-1:0]  flush_count_o
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_STAGES-1:1]    valid_q, valid_d;
    logic [COUNTER_WIDTH-1:0] retired_q, retired_d;
    logic [COUNTER_WIDTH-1:0] stallc_q, stallc_d;
    logic [COUNTER_WIDTH-1:0] flushc_q, flushc_d;

    logic [NUM_STAGES-1:0] valid;
    logic                  load_use;
    logic                  branch_ok;
    logic                  any_stall;
    logic [NUM_STAGES-1:0] stall_raw;
    logic [NUM_STAGES-1:0] flush_raw;
    int                    freeze;

    assign valid = {valid_q, 1'b1};

    always_comb begin
        load_use = ex_mem_read_i & valid[EX_STAGE] & (ex_rd_i != '0) & valid[EX_STAGE-1]
                 & ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
        // Only a freeze at or above EX can block a redirect; the branch then
        // waits in the held EX register and is re-evaluated next cycle.
        branch_ok = ex_branch_taken_i & valid[EX_STAGE] & ~mem_stall_i & ~ex_busy_i;

        if (mem_stall_i)       freeze = MEM_STAGE;
        else if (ex_busy_i)    freeze = EX_STAGE;
        else if (branch_ok)    freeze = -1;
        else if (load_use)     freeze = EX_STAGE - 1;
        else if (if_stall_i)   freeze = 0;
        else                   freeze = -1;

        any_stall = (freeze >= 0);
        stall_raw = '0;
        flush_raw = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stall_raw[k] = (k <= freeze) && (k != NUM_STAGES - 1);
            flush_raw[k] = (any_stall && (k == freeze + 1))
                         || (branch_ok && (k >= 1) && (k <= EX_STAGE));
        end

        stall_o = reset_i ? '0 : stall_raw;
        flush_o = reset_i ? '1 : flush_raw;
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (stall_raw[k])      valid_d[k] = valid_q[k];
            else if (flush_raw[k]) valid_d[k] = 1'b0;
            else                   valid_d[k] = valid[k-1];
        end
        retired_d = retired_q;
        stallc_d  = stallc_q;
        flushc_d  = flushc_q;
        if (valid[NUM_STAGES-1] && (retired_q != CNT_MAX)) retired_d = retired_q + CNT_ONE;
        if (any_stall && (stallc_q != CNT_MAX))            stallc_d  = stallc_q + CNT_ONE;
        if (branch_ok && (flushc_q != CNT_MAX))            flushc_d  = flushc_q + CNT_ONE;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q   <= '0;
            retired_q <= '0;
            stallc_q  <= '0;
            flushc_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            retired_q <= retired_d;
            stallc_q  <= stallc_d;
            flushc_q  <= flushc_d;
        end
    end

    assign stage_valid_o   = valid;
    assign retired_count_o = retired_q;
    assign stall_cycles_o  = stallc_q;
    assign flush_count_o   = flushc_q;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - self-checking bench for pipeline_control
module tb_pipeline_control;

    localparam int N   = 5;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int RW  = 5;

    logic          clock = 1'b0;
    logic          reset, if_stall, mem_stall, ex_busy, br_taken;
    logic [RW-1:0] rs1, rs2, ex_rd;
    logic          uses1, uses2, mem_read;

    logic [N-1:0]  stall, flush, valid;
    logic [31:0]   ret, stc, flc;
    logic [N-1:0]  s_stall, s_flush, s_valid;
    logic [3:0]    s_ret, s_stc, s_flc;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [N-1:0] mv;
    longint       m_ret, m_stc, m_flc;
    bit           known = 0;
    int           mf;
    bit           macc;
    logic [N-1:0] e_stall, e_flush;

    always #5 clock = ~clock;

    pipeline_control #(.COUNTER_WIDTH(32)) u_dut (
        .clock_i(clock), .reset_i(reset), .if_stall_i(if_stall), .mem_stall_i(mem_stall),
        .ex_busy_i(ex_busy), .ex_branch_taken_i(br_taken), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2), .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read),
        .stall_o(stall), .flush_o(flush), .stage_valid_o(valid),
        .retired_count_o(ret), .stall_cycles_o(stc), .flush_count_o(flc));

    pipeline_control #(.COUNTER_WIDTH(4)) u_small (
        .clock_i(clock), .reset_i(reset), .if_stall_i(if_stall), .mem_stall_i(mem_stall),
        .ex_busy_i(ex_busy), .ex_branch_taken_i(br_taken), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2), .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read),
        .stall_o(s_stall), .flush_o(s_flush), .stage_valid_o(s_valid),
        .retired_count_o(s_ret), .stall_cycles_o(s_stc), .flush_count_o(s_flc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_comb();
        bit lu;
        lu = mem_read && mv[EX] && (ex_rd != 0) && mv[EX-1]
             && ((uses1 && rs1 == ex_rd) || (uses2 && rs2 == ex_rd));
        macc = 0;
        if (mem_stall)               mf = MEM;
        else if (ex_busy)            mf = EX;
        else if (br_taken && mv[EX]) begin mf = -1; macc = 1; end
        else if (lu)                 mf = EX - 1;
        else if (if_stall)           mf = 0;
        else                         mf = -1;
        e_stall = '0;
        e_flush = '0;
        // every stage up to and including the freeze point holds, the next one gets a bubble
        for (int k = 0; k <= mf; k++) e_stall[k] = 1'b1;
        if (mf >= 0) e_flush[mf+1] = 1'b1;
        if (macc) for (int k = 1; k <= EX; k++) e_flush[k] = 1'b1;
        if (reset) begin
            e_stall = '0;
            e_flush = '1;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] nv;
        if (reset) begin
            mv = 5'b00001;
            m_ret = 0; m_stc = 0; m_flc = 0;
            known = 1;
        end else begin
            m_ret = m_ret + (mv[N-1] ? 1 : 0);
            m_stc = m_stc + ((mf >= 0) ? 1 : 0);
            m_flc = m_flc + (macc ? 1 : 0);
            nv = mv;
            for (int k = 1; k < N; k++)
                nv[k] = e_stall[k] ? mv[k] : (e_flush[k] ? 1'b0 : mv[k-1]);
            mv = nv;
        end
    endtask

    task automatic cycle();
        #1;
        model_comb();
        chk("stall", stall, e_stall);
        chk("flush", flush, e_flush);
        chk("small_stall", s_stall, e_stall);
        if (known) begin
            chk("valid", valid, mv);
            chk("retired", ret, sat(m_ret, 64'hFFFF_FFFF));
            chk("stall_cycles", stc, sat(m_stc, 64'hFFFF_FFFF));
            chk("flush_count", flc, sat(m_flc, 64'hFFFF_FFFF));
            chk("small_retired", s_ret, sat(m_ret, 15));
            chk("small_stall_cycles", s_stc, sat(m_stc, 15));
            chk("small_flush_count", s_flc, sat(m_flc, 15));
        end
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 0; if_stall = 0; mem_stall = 0; ex_busy = 0; br_taken = 0;
        rs1 = 0; rs2 = 0; ex_rd = 0; uses1 = 0; uses2 = 0; mem_read = 0;
    endtask

    initial begin
        idle();
        mv = 5'b00001; m_ret = 0; m_stc = 0; m_flc = 0;
        @(negedge clock);

        // reset two cycles, then ten hazard-free cycles
        reset = 1;
        repeat (2) cycle();
        reset = 0;
        repeat (10) cycle();
        chk("fill_valid", valid, 5'b11111);
        chk("fill_retired", ret, 6);
        chk("fill_stall_cycles", stc, 0);

        // load-use interlock
        mem_read = 1; ex_rd = 5; rs1 = 5; uses1 = 1;
        #1;
        chk("lu_stall", stall, 5'b00011);
        chk("lu_flush", flush, 5'b00100);
        cycle();
        idle();
        #1;
        chk("lu_after_stall", stall, 5'b00000);
        chk("lu_stall_cycles", stc, 1);
        cycle();

        // multi-cycle ALU busy for four cycles
        ex_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("busy_stall", stall, 5'b00111);
            chk("busy_flush", flush, 5'b01000);
            cycle();
        end
        idle();
        chk("busy_valid3", valid[3], 1'b0);
        chk("busy_stall_cycles", stc, 5);

        // taken branch with no stall
        br_taken = 1;
        #1;
        chk("br_flush", flush, 5'b00110);
        chk("br_stall", stall, 5'b00000);
        cycle();
        idle();
        chk("br_valid21", valid[2:1], 2'b00);
        chk("br_flush_count", flc, 1);
        repeat (3) cycle();

        // taken branch blocked by data-cache stall for three cycles
        br_taken = 1; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("brms_flush", flush, 5'b10000);
            cycle();
        end
        mem_stall = 0;
        #1;
        chk("brms_accept_flush", flush, 5'b00110);
        cycle();
        idle();
        chk("brms_flush_count", flc, 2);

        // saturation of the narrow counters
        repeat (20) cycle();
        chk("sat_retired", s_ret, 4'hF);

        // reset pulse in the middle of a stall
        mem_stall = 1;
        cycle();
        reset = 1;
        cycle();
        idle();
        chk("rst_valid", valid, 5'b00001);
        chk("rst_retired", ret, 0);
        chk("rst_stall_cycles", stc, 0);
        chk("rst_flush_count", flc, 0);

        // randomized hazards against the reference model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            mem_stall = ($urandom_range(0, 7) == 0);
            ex_busy   = ($urandom_range(0, 7) == 0);
            if_stall  = ($urandom_range(0, 5) == 0);
            br_taken  = ($urandom_range(0, 4) == 0);
            mem_read  = $urandom_range(0, 1);
            uses1     = $urandom_range(0, 1);
            uses2     = $urandom_range(0, 1);
            rs1       = RW'($urandom_range(0, 3));
            rs2       = RW'($urandom_range(0, 3));
            ex_rd     = RW'($urandom_range(0, 3));
            cycle();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
